// File: rtl/mixcol_pkg.sv
// Shared definitions for the MixColumns engine: GF(2^8) helpers and FSM states.
package mixcol_pkg;

  // AES reduction polynomial x^8 + x^4 + x^3 + x + 1 with the x^8 term dropped.
  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Multiply by 02 in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // 09 = 08 ^ 01
  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b;
  endfunction

  // 0b = 08 ^ 02 ^ 01
  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b2 ^ b;
  endfunction

  // 0d = 08 ^ 04 ^ 01
  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b;
  endfunction

  // 0e = 08 ^ 04 ^ 02
  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b2;
  endfunction

endpackage

// File: rtl/mix_column_core.sv
// Combinational MixColumns / InvMixColumns on a single 32-bit column.
// Row 0 is the MSB byte of the column.
module mix_column_core
  import mixcol_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [7:0] a [4];
  logic [7:0] r [4];

  for (genvar i = 0; i < 4; i++) begin : g_split
    assign a[i] = col_i[31-8*i -: 8];
  end

  // Each output row uses the coefficient row rotated right by the row index.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (inv_i) begin
        r[i] = gf_mule(a[i]) ^ gf_mulb(a[(i+1)%4]) ^ gf_muld(a[(i+2)%4]) ^ gf_mul9(a[(i+3)%4]);
      end else begin
        r[i] = xtime(a[i]) ^ gf_mul3(a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
  end

  assign col_o = {r[0], r[1], r[2], r[3]};

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential MixColumns / InvMixColumns engine for a full 128-bit AES state.
// COLS_PER_CYCLE columns are transformed per clock, BEATS = 4/COLS_PER_CYCLE beats per block.
// Optional feature: define MIXCOL_ADDKEY_EN to add in_key, XORed into the result on the
// final beat (equivalent-inverse-cipher round key).
module mix_columns_engine
  import mixcol_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
`ifdef MIXCOL_ADDKEY_EN
  input  logic [127:0] in_key,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned BEATS = 4 / COLS_PER_CYCLE;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e             state_q, state_d;
  logic [127:0]       buf_q, buf_d;
  logic               inv_q, inv_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [127:0]       out_state_q, out_state_d;
`ifdef MIXCOL_ADDKEY_EN
  logic [127:0]       key_q, key_d;
`endif

  logic [31:0]        core_in  [COLS_PER_CYCLE];
  logic [31:0]        core_out [COLS_PER_CYCLE];
  logic [127:0]       new_buf;
  logic [127:0]       final_blk;

  // Route the columns belonging to the current beat into the cores.
  always_comb begin
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      core_in[g] = '0;
    end
    for (int unsigned c = 0; c < 4; c++) begin
      if (32'(beat_q) == c / COLS_PER_CYCLE) begin
        core_in[c % COLS_PER_CYCLE] = buf_q[127-32*c -: 32];
      end
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_core
    mix_column_core u_core (
      .col_i (core_in[g]),
      .inv_i (inv_q),
      .col_o (core_out[g])
    );
  end

  // Write the transformed columns back in place; other columns pass through.
  always_comb begin
    new_buf = buf_q;
    for (int unsigned c = 0; c < 4; c++) begin
      if (32'(beat_q) == c / COLS_PER_CYCLE) begin
        new_buf[127-32*c -: 32] = core_out[c % COLS_PER_CYCLE];
      end
    end
  end

`ifdef MIXCOL_ADDKEY_EN
  assign final_blk = new_buf ^ key_q;
`else
  assign final_blk = new_buf;
`endif

  // Next-state logic for the IDLE -> BUSY -> DONE block pipeline.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    inv_d       = inv_q;
    beat_d      = beat_q;
    out_state_d = out_state_q;
`ifdef MIXCOL_ADDKEY_EN
    key_d       = key_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          buf_d   = in_state;
          inv_d   = in_inv;
`ifdef MIXCOL_ADDKEY_EN
          key_d   = in_key;
`endif
          beat_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        buf_d = new_buf;
        if (beat_q == BeatW'(BEATS - 1)) begin
          out_state_d = final_blk;
          beat_d      = '0;
          state_d     = StDone;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      inv_q       <= 1'b0;
      beat_q      <= '0;
      out_state_q <= '0;
`ifdef MIXCOL_ADDKEY_EN
      key_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      inv_q       <= inv_d;
      beat_q      <= beat_d;
      out_state_q <= out_state_d;
`ifdef MIXCOL_ADDKEY_EN
      key_q       <= key_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_state = out_state_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench: three engines (1, 2 and 4 columns per cycle) driven by directed vectors.
module tb_mix_columns_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  logic [2:0]   in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_state  [3];
  logic [127:0] out_state [3];
`ifdef MIXCOL_ADDKEY_EN
  logic [127:0] in_key    [3];
`endif

  logic [127:0] exp_q [3][$];
  int           acc_cyc [3];

  localparam logic [127:0] VecA = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};
  localparam logic [127:0] VecB = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};

  task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned C = 1 << g;
    logic ov_prev;

    mix_columns_engine #(.COLS_PER_CYCLE(C)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_inv    (in_inv[g]),
`ifdef MIXCOL_ADDKEY_EN
      .in_key    (in_key[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );

    always @(negedge clk) begin
      if (rst) ov_prev <= 1'b0;
      else     ov_prev <= out_valid[g];
    end

    // Monitor: latency on the rising edge of out_valid, data on each handshake.
    always @(negedge clk) begin
      if (!rst) begin
        if (out_valid[g] && !ov_prev) begin
          check_int($sformatf("latency_dut%0d", g), cyc - acc_cyc[g], int'(4 / C));
        end
        if (out_valid[g] && out_ready[g]) begin
          if (exp_q[g].size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL unexpected_output_dut%0d: got %h expected no output", g, out_state[g]);
          end else begin
            check_vec($sformatf("data_dut%0d", g), out_state[g], exp_q[g].pop_front());
          end
        end
      end
    end
  end

  // Offer a block, wait for acceptance, then scramble the inputs to show they are ignored.
  task automatic send(input int i, input logic [127:0] s, input logic inv,
                      input logic [127:0] exp);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid[i] = 1'b1;
    in_state[i] = s;
    in_inv[i]   = inv;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errs++;
      $display("FAIL accept_timeout_dut%0d: got in_ready=0 expected 1 within 60 cycles", i);
      in_valid[i] = 1'b0;
    end else begin
      acc_cyc[i] = cyc + 1;
      exp_q[i].push_back(exp);
      @(posedge clk); #1;
      in_valid[i] = 1'b0;
      in_state[i] = ~s;
      in_inv[i]   = ~inv;
    end
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < 100 && exp_q[i].size() != 0; k++) @(negedge clk);
    if (exp_q[i].size() != 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain_timeout_dut%0d: got %0d pending expected 0", i, exp_q[i].size());
      exp_q[i].delete();
    end
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = '0;
    in_inv    = '0;
    out_ready = '1;
    for (int i = 0; i < 3; i++) begin
      in_state[i] = '0;
      acc_cyc[i]  = 0;
`ifdef MIXCOL_ADDKEY_EN
      in_key[i]   = '0;
`endif
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_int($sformatf("rst_in_ready_dut%0d", i), int'(in_ready[i]), 1);
      check_int($sformatf("rst_out_valid_dut%0d", i), int'(out_valid[i]), 0);
      check_vec($sformatf("rst_out_state_dut%0d", i), out_state[i], '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Forward, one column per cycle
    send(0, {4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
    drain(0);

    // Inverse, one column per cycle
    send(0, VecB, 1'b1, VecA);
    drain(0);

    // Round trip through every width, back to back
    for (int i = 0; i < 3; i++) begin
      send(i, VecA, 1'b0, VecB);
      send(i, VecB, 1'b1, VecA);
      drain(i);
    end

    // Backpressure on the two-column engine
    out_ready[1] = 1'b0;
    send(1, {4{32'h2d26314c}}, 1'b0, {4{32'h4d7ebdf8}});
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid[1]) begin
        seen = 1'b1;
        break;
      end
    end
    check_int("stall_out_valid_seen", int'(seen), 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid[1] = 1'b1;
      in_state[1] = VecB;
      in_inv[1]   = 1'b1;
      @(negedge clk);
      if (k % 3 == 0) begin
        check_vec($sformatf("stall_hold_%0d", k), out_state[1], {4{32'h4d7ebdf8}});
        check_int($sformatf("stall_in_ready_%0d", k), int'(in_ready[1]), 0);
        check_int($sformatf("stall_out_valid_%0d", k), int'(out_valid[1]), 1);
      end
    end
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    send(1, VecB, 1'b1, VecA);
    drain(1);

    // Reset while BUSY at beat 2
    send(0, VecA, 1'b0, VecB);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q[0].delete();
    @(negedge clk);
    check_int("midrst_out_valid", int'(out_valid[0]), 0);
    check_int("midrst_in_ready", int'(in_ready[0]), 1);
    check_vec("midrst_out_state", out_state[0], '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("postrst_in_ready", int'(in_ready[0]), 1);
    check_int("postrst_out_valid", int'(out_valid[0]), 0);
    send(0, {4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}});
    drain(0);

`ifdef MIXCOL_ADDKEY_EN
    // Round-key XOR on the final beat
    in_key[0] = '1;
    send(0, {4{32'h2d26314c}}, 1'b0, {4{32'hb2814207}});
    drain(0);
    in_key[0] = '0;
`endif

    for (int i = 0; i < 3; i++) drain(i);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
